// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier result collector.
//   LANES/WIDTH : lane count and FP word width
//   mode_e      : lane-enable select (1, 2, 4 or 6 lanes)
//   bundle_t    : one complete set of lane products plus its enable mask
//   lane_mask() : mode -> contiguous enable mask starting at lane 0
//   last_lane() : index of the highest enabled lane in a mask
package mul_pkg;

    localparam int unsigned LANES  = 6;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned LANE_W = 3;

    typedef enum logic [1:0] {
        MODE_1 = 2'b00,
        MODE_2 = 2'b01,
        MODE_4 = 2'b10,
        MODE_6 = 2'b11
    } mode_e;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    typedef struct packed {
        logic [LANES-1:0][WIDTH-1:0] data;
        logic [LANES-1:0]            mask;
    } bundle_t;

    function automatic logic [LANES-1:0] lane_mask(input mode_e mode);
        case (mode)
            MODE_1:  return LANES'(6'b000001);
            MODE_2:  return LANES'(6'b000011);
            MODE_4:  return LANES'(6'b001111);
            MODE_6:  return LANES'(6'b111111);
            default: return LANES'(6'b000001);
        endcase
    endfunction

    function automatic logic [LANE_W-1:0] last_lane(input logic [LANES-1:0] mask);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask[i]) r = LANE_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Small circular buffer of complete bundles between collector and serializer.
//   clk, rst   : clock, synchronous active-low reset
//   push, din  : write request and bundle (accepted when not full, or full with a pop)
//   pop, dout  : read request and head bundle (pop ignored when empty)
//   full/empty : occupancy flags derived from registered pointers
module bundle_fifo
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  bundle_t din,
    input  logic    pop,
    output bundle_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bundle_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mul_result_collector.sv
// Collects per-lane FP products into bundles, buffers them and streams them
// lane by lane over a valid/ready port.
//   clk, rst          : clock, synchronous active-low reset
//   mode              : lane-enable select, latched at the first accepted strobe
//   products/prod_stbs: lane products and their 1-cycle valid strobes
//   out_*             : serialized beat (data, lane index, last flag, valid), out_ready accepts
//   busy              : partial or complete-but-unbuffered bundle held in the collector
//   dup_err/ovf_err   : sticky duplicate-strobe and dropped-strobe flags
module mul_result_collector
    import mul_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] products,
    input  logic [LANES-1:0]       prod_stbs,
    output logic [WIDTH-1:0]       out_data,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   dup_err,
    output logic                   ovf_err
);

    // Collector state
    logic [LANES-1:0]            arrived, arrived_n;
    logic [LANES-1:0]            mask_q, mask_n, eff_mask, acc;
    logic [LANES-1:0][WIDTH-1:0] data_q, data_n;
    logic                        hold, hold_n;
    logic                        dup_hit, ovf_hit, push, can_push;
    bundle_t                     push_bundle;

    // FIFO / serializer
    bundle_t                     head, beat_q, beat_n;
    logic                        fifo_full, fifo_empty, pop;
    ser_state_e                  state, state_n;
    logic                        xfer, load;
    logic [WIDTH-1:0]            data_nx;
    logic [LANE_W-1:0]           lane_nx, lane_inc;
    logic                        last_nx, valid_nx;

    assign can_push = ~fifo_full | pop;

    // Collector: capture strobes, detect completion, push or stall in HOLD.
    always_comb begin
        acc       = '0;
        dup_hit   = 1'b0;
        ovf_hit   = 1'b0;
        push      = 1'b0;
        arrived_n = arrived;
        hold_n    = hold;
        mask_n    = mask_q;
        data_n    = data_q;
        // A fresh bundle takes its mask from the live mode; an open one keeps its latched mask.
        eff_mask  = (arrived == '0) ? lane_mask(mode_e'(mode)) : mask_q;
        if (hold) begin
            ovf_hit = |prod_stbs;
            if (can_push) begin
                push      = 1'b1;
                hold_n    = 1'b0;
                arrived_n = '0;
            end
        end else begin
            acc     = prod_stbs & eff_mask & ~arrived;
            dup_hit = |(prod_stbs & eff_mask & arrived);
            for (int i = 0; i < int'(LANES); i++) begin
                if (acc[i]) data_n[i] = products[i*WIDTH +: WIDTH];
            end
            if (acc != '0) begin
                mask_n    = eff_mask;
                arrived_n = arrived | acc;
                if (arrived_n == eff_mask) begin
                    if (can_push) begin
                        push      = 1'b1;
                        arrived_n = '0;
                    end else begin
                        hold_n = 1'b1;
                    end
                end
            end
        end
    end

    assign push_bundle.data = data_n;
    assign push_bundle.mask = mask_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            arrived <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            hold    <= 1'b0;
            busy    <= 1'b0;
            dup_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            arrived <= arrived_n;
            mask_q  <= mask_n;
            data_q  <= data_n;
            hold    <= hold_n;
            busy    <= (arrived_n != '0) | hold_n;
            dup_err <= dup_err | dup_hit;
            ovf_err <= ovf_err | ovf_hit;
        end
    end

    bundle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_bundle),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign xfer = out_valid & out_ready;

    // Serializer state register
    always_ff @(posedge clk) begin
        if (!rst) state <= SER_IDLE;
        else      state <= state_n;
    end

    // Serializer next state
    always_comb begin
        state_n = state;
        case (state)
            SER_IDLE: if (!fifo_empty) state_n = SER_SEND;
            SER_SEND: if (xfer && out_last && fifo_empty) state_n = SER_IDLE;
            default:  state_n = SER_IDLE;
        endcase
    end

    // Serializer outputs: load a new head (also back-to-back after a last beat) or advance lanes.
    always_comb begin
        pop      = 1'b0;
        beat_n   = beat_q;
        valid_nx = out_valid;
        data_nx  = out_data;
        lane_nx  = out_lane;
        last_nx  = out_last;
        lane_inc = out_lane + LANE_W'(1);
        load     = !fifo_empty && ((state == SER_IDLE) || (state == SER_SEND && xfer && out_last));
        if (load) begin
            pop      = 1'b1;
            beat_n   = head;
            valid_nx = 1'b1;
            lane_nx  = '0;
            data_nx  = head.data[0];
            last_nx  = (last_lane(head.mask) == '0);
        end else if (state == SER_SEND && xfer) begin
            if (out_last) begin
                valid_nx = 1'b0;
            end else begin
                lane_nx = lane_inc;
                data_nx = beat_q.data[lane_inc];
                last_nx = (lane_inc == last_lane(beat_q.mask));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else begin
            beat_q    <= beat_n;
            out_valid <= valid_nx;
            out_data  <= data_nx;
            out_lane  <= lane_nx;
            out_last  <= last_nx;
        end
    end

endmodule

// File: tb/tb_mul_result_collector.sv
// Directed bench for mul_result_collector: latency, lane masking, duplicate and
// overflow flags, back-to-back streaming, random backpressure and reset recovery.
module tb_mul_result_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [191:0] products = '0;
    logic [5:0]   prod_stbs = '0;
    logic [31:0]  out_data;
    logic [2:0]   out_lane;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         dup_err;
    logic         ovf_err;

    mul_result_collector #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .products  (products),
        .prod_stbs (prod_stbs),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .dup_err   (dup_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  lane;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    xfer_cnt = 0;
    bit    rnd_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] en_of(input logic [1:0] m);
        case (m)
            2'b00:   return 6'b000001;
            2'b01:   return 6'b000011;
            2'b10:   return 6'b001111;
            default: return 6'b111111;
        endcase
    endfunction

    task automatic expect_bundle(input logic [1:0] m, input logic [5:0][31:0] d);
        logic [5:0] en;
        int hi;
        beat_t b;
        en = en_of(m);
        hi = 0;
        for (int i = 0; i < 6; i++) if (en[i]) hi = i;
        for (int i = 0; i < 6; i++) begin
            if (en[i]) begin
                b.data = d[i];
                b.lane = 3'(i);
                b.last = (i == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    // Cycle 0 strobes 'first' as given; cycle 1 strobes any enabled lane not yet strobed.
    task automatic drive_bundle(input logic [1:0] m, input logic [5:0][31:0] d,
                                input logic [5:0] first, input bit expect_it);
        logic [5:0] rest;
        rest = en_of(m) & ~first;
        if (expect_it) expect_bundle(m, d);
        mode      = m;
        products  = d;
        prod_stbs = first;
        tick();
        if (rest != '0) begin
            prod_stbs = rest;
            tick();
        end
        prod_stbs = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Random backpressure, driven away from the bench's own stimulus instant.
    always @(posedge clk) begin
        #2;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Beat monitor: scoreboard each transfer, and hold-stability while stalled.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_d = '0;
    logic [2:0]  prev_l = '0;
    beat_t       mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data",  out_data, prev_d);
                chk("stall_lane",  32'(out_lane), 32'(prev_l));
                chk("stall_last",  32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", out_data, mon_e.data);
                    chk("beat_lane", 32'(out_lane), 32'(mon_e.lane));
                    chk("beat_last", 32'(out_last), 32'(mon_e.last));
                end
            end
            prev_v    = out_valid;
            prev_r    = out_ready;
            prev_d    = out_data;
            prev_l    = out_lane;
            prev_last = out_last;
        end
    end

    initial begin
        logic [5:0][31:0] d;
        int n;
        int c0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_lane",  32'(out_lane), 32'd0);
        chk("rst_last",  32'(out_last), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_dup",   32'(dup_err), 32'd0);
        chk("rst_ovf",   32'(ovf_err), 32'd0);
        rst = 1'b1;
        tick();

        // T1: staggered strobes, mode 11, check 2-cycle latency
        out_ready = 1'b1;
        mode = 2'b11;
        for (int i = 0; i < 6; i++) d[i] = 32'h3F80_0000 + 32'(i);
        expect_bundle(2'b11, d);
        products = d;
        for (int i = 0; i < 6; i++) begin
            prod_stbs = 6'(1 << i);
            tick();
        end
        prod_stbs = '0;
        chk("t1_busy_after_last", 32'(busy), 32'd0);
        chk("t1_lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat_valid", 32'(out_valid), 32'd1);
        chk("t1_first_lane", 32'(out_lane), 32'd0);
        chk("t1_first_data", out_data, 32'h3F80_0000);
        chk("t1_first_last", 32'(out_last), 32'd0);
        wait_drain("t1_drain", 50);

        // T2: mode 01 with all six strobes at once -> only lanes 0,1
        for (int i = 0; i < 6; i++) d[i] = 32'hA000_0000 + 32'(i);
        drive_bundle(2'b01, d, 6'b111111, 1'b1);
        wait_drain("t2_drain", 50);
        chk("t2_dup", 32'(dup_err), 32'd0);
        chk("t2_ovf", 32'(ovf_err), 32'd0);

        // T4: duplicate strobe on lane 2 keeps the first value
        for (int i = 0; i < 6; i++) d[i] = 32'h5000_0000 + 32'(i);
        d[2] = 32'h4000_0000;
        expect_bundle(2'b11, d);
        mode = 2'b11;
        products = d;
        prod_stbs = 6'b000111;
        tick();
        chk("t4_busy_partial", 32'(busy), 32'd1);
        products[2*32 +: 32] = 32'h4040_0000;
        prod_stbs = 6'b000100;
        tick();
        chk("t4_dup", 32'(dup_err), 32'd1);
        prod_stbs = 6'b111000;
        tick();
        prod_stbs = '0;
        wait_drain("t4_drain", 50);

        // T3: stall output, fill serializer + FIFO, fourth bundle goes to HOLD
        out_ready = 1'b0;
        tick();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) d[i] = 32'h1000_0000 + 32'(b * 16 + i);
            drive_bundle(2'b11, d, 6'b111111, 1'b1);
        end
        chk("t3_hold_busy", 32'(busy), 32'd1);
        chk("t3_ovf_before", 32'(ovf_err), 32'd0);
        products = {6{32'hDEAD_BEEF}};
        prod_stbs = 6'b001000;
        tick();
        prod_stbs = '0;
        chk("t3_ovf", 32'(ovf_err), 32'd1);
        chk("t3_still_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        c0 = xfer_cnt;
        repeat (24) tick();
        chk("t3_b2b_beats", 32'(xfer_cnt - c0), 32'd24);
        chk("t3_busy_clear", 32'(busy), 32'd0);
        wait_drain("t3_drain", 20);

        // T6: reset while SEND is stalled and a partial bundle is open
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) d[i] = 32'h7000_0000 + 32'(i);
        drive_bundle(2'b11, d, 6'b111111, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t6_in_send", 32'(out_valid), 32'd1);
        prod_stbs = 6'b000011;
        tick();
        prod_stbs = '0;
        chk("t6_partial_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_lane",  32'(out_lane), 32'd0);
        chk("t6_busy",  32'(busy), 32'd0);
        chk("t6_dup",   32'(dup_err), 32'd0);
        chk("t6_ovf",   32'(ovf_err), 32'd0);
        tick();
        tick();
        chk("t6_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) d[i] = 32'h7100_0000 + 32'(i);
        drive_bundle(2'b11, d, 6'b010101, 1'b1);
        wait_drain("t6_drain", 50);

        // T5: 20 bundles, random modes/split strobes, random backpressure
        rnd_en = 1'b1;
        for (int b = 0; b < 20; b++) begin
            n = 0;
            while (busy && n < 200) begin
                tick();
                n++;
            end
            chk("t5_busy_wait", 32'(busy), 32'd0);
            for (int i = 0; i < 6; i++) d[i] = $urandom;
            drive_bundle(2'($urandom_range(0, 3)), d, 6'($urandom), 1'b1);
        end
        rnd_en = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_drain("t5_drain", 400);
        chk("t5_ovf", 32'(ovf_err), 32'd0);
        chk("t5_dup", 32'(dup_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
